eq_stream_sched: RTL
====================

EQ_STREAM_SCHED -- requirements
Module: eq_stream_sched

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets per-side output compare FIFO depth in entries; power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 1023, sets max consecutive cycles with no handshake in RUN/DRAIN before abort.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse; begins a run.
REQ-006 num_pix  in  19  input pixels to issue; sampled on accepted start.
REQ-007 exp_out  in  19  output pixels expected per side; sampled on accepted start.
REQ-008 src_tdata / src_tvalid / src_tready  in 8 / in 1 / out 1  shared upstream pixel stream.
REQ-009 a_in_tdata / a_in_tvalid / a_in_tready  out 8 / out 1 / in 1  pixel stream to model A; b_in_* identical for model B.
REQ-010 a_out_tdata / a_out_tvalid / a_out_tready  in 8 / in 1 / out 1  result stream from model A; b_out_* identical for model B.
REQ-011 a_step, b_step  out  1  step enables to models A and B.
REQ-012 busy, done, mismatch, timeout  out  1  status flags.
REQ-013 out_cnt  out  19  compared output pairs; mismatch_idx  out  19  index of first mismatching pair.

Function
REQ-014 FSM states IDLE, RUN, DRAIN, DONE; busy=1 exactly in RUN or DRAIN; done=1 exactly in DONE.
REQ-015 IDLE or DONE + start=1 -> RUN next cycle; clears in_cnt, out_cnt, mismatch, mismatch_idx, timeout, idle counter, FIFOs; start ignored in RUN/DRAIN.
REQ-016 src_tready = RUN & !a_pend & !b_pend & (in_cnt < num_pix); combinational, no dependence on src_tvalid.
REQ-017 Source beat accepted (src_tvalid&src_tready): data loaded into both a_in and b_in holding regs, a_pend=b_pend=1, in_cnt+1.
REQ-018 a_in_tvalid=a_pend, a_in_tdata=holding reg; a_pend clears on a_in_tvalid&a_in_tready; B independent; A/B skew at most one beat.
REQ-019 RUN -> DRAIN when in_cnt==num_pix and a_pend==b_pend==0; num_pix=0 gives DRAIN one cycle after entering RUN.
REQ-020 a_out_tready = busy & A FIFO not full; accepted A output beat pushes A FIFO; B symmetric.
REQ-021 Each FIFO supports push and pop in same cycle, including when full (pop frees slot but tready uses registered full, no bypass).
REQ-022 Compare pop: when both FIFOs non-empty and busy, pop one entry each, out_cnt+1; heads unequal and mismatch==0 -> mismatch=1, mismatch_idx=out_cnt (pre-increment value); later mismatches do not update.
REQ-023 DRAIN -> DONE when out_cnt==exp_out; exp_out=0 -> DONE at first DRAIN cycle.
REQ-024 Output beats beyond exp_out in RUN are pushed and compared; out_cnt saturates at 2^19-1.
REQ-025 Idle counter increments each busy cycle with no handshake on src, a_in, b_in, a_out, b_out; resets to 0 on any handshake; reaching TIMEOUT -> DONE with timeout=1.
REQ-026 a_step = b_step = busy; both 0 in IDLE/DONE.
REQ-027 In IDLE/DONE all tready/tvalid outputs 0; status and counters hold until next accepted start.

Reset
REQ-028 rst=1 -> IDLE, both FIFOs empty, a_pend=b_pend=0, all outputs 0, counters 0; rst takes priority over start and aborts any run mid-operation, discarding pending and buffered data.

Verification
REQ-029 start, num_pix=4, exp_out=4, src 0x10,0x20,0x30,0x40, both models echo, always ready -> 4 pairs compared, out_cnt=4, done=1, mismatch=0.
REQ-030 As REQ-029 but B returns 0x31 for third beat -> mismatch=1, mismatch_idx=2, done=1 after 4th pair.
REQ-031 a_in_tready held 0 for 5 cycles, B always ready -> src_tready=0 during stall, b_in carries one beat only, no data loss, in_cnt correct.
REQ-032 B output silent, A produces 6 beats, FIFO_DEPTH=4 -> a_out_tready drops after 4 pushes; B then delivers -> 4 pops, A resumes, all 6 compared.
REQ-033 TIMEOUT=8, src_tvalid held 0 after start -> DONE on 8th idle cycle, timeout=1, busy=0.
REQ-034 rst asserted mid-RUN with a_pend=1, FIFOs non-empty -> next cycle IDLE, all flags/counters 0; following start runs cleanly.

Source files
------------

// File: rtl/eq_stream_sched.sv
// eq_stream_sched: feeds one pixel stream to two models in lockstep and compares their result streams.
module eq_stream_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [18:0] num_pix,
  input  logic [18:0] exp_out,
  input  logic [7:0]  src_tdata,
  input  logic        src_tvalid,
  output logic        src_tready,
  output logic [7:0]  a_in_tdata,
  output logic        a_in_tvalid,
  input  logic        a_in_tready,
  output logic [7:0]  b_in_tdata,
  output logic        b_in_tvalid,
  input  logic        b_in_tready,
  input  logic [7:0]  a_out_tdata,
  input  logic        a_out_tvalid,
  output logic        a_out_tready,
  input  logic [7:0]  b_out_tdata,
  input  logic        b_out_tvalid,
  output logic        b_out_tready,
  output logic        a_step,
  output logic        b_step,
  output logic        busy,
  output logic        done,
  output logic        mismatch,
  output logic        timeout,
  output logic [18:0] out_cnt,
  output logic [18:0] mismatch_idx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [18:0] num_pix_r, exp_out_r, in_cnt;
  logic [TW-1:0] idle_cnt;
  logic a_pend, b_pend;
  logic [7:0] a_hold, b_hold;
  logic [7:0] a_mem [FIFO_DEPTH];
  logic [7:0] b_mem [FIFO_DEPTH];
  logic [AW:0] a_wr, a_rd, b_wr, b_rd;
  logic a_full, b_full, a_empty, b_empty;
  logic go, src_hs, a_in_hs, b_in_hs, a_out_hs, b_out_hs, any_hs, pop, tmo_hit;
  assign a_in_tdata = a_hold;
  assign b_in_tdata = b_hold;
  assign a_empty = a_wr == a_rd;
  assign b_empty = b_wr == b_rd;
  // full when write pointer has lapped read pointer; taken from registers only, so a same-cycle pop never bypasses
  assign a_full = a_wr == {~a_rd[AW], a_rd[AW-1:0]};
  assign b_full = b_wr == {~b_rd[AW], b_rd[AW-1:0]};
  assign go = start && (state == IDLE || state == DONE);
  assign src_hs = src_tvalid && src_tready;
  assign a_in_hs = a_in_tvalid && a_in_tready;
  assign b_in_hs = b_in_tvalid && b_in_tready;
  assign a_out_hs = a_out_tvalid && a_out_tready;
  assign b_out_hs = b_out_tvalid && b_out_tready;
  assign any_hs = src_hs || a_in_hs || b_in_hs || a_out_hs || b_out_hs;
  assign pop = busy && !a_empty && !b_empty;
  assign tmo_hit = busy && !any_hs && idle_cnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = go ? RUN
             : state == RUN ? (tmo_hit ? DONE
                               : (in_cnt == num_pix_r && !a_pend && !b_pend) ? DRAIN : RUN)
             : state == DRAIN ? ((tmo_hit || out_cnt == exp_out_r) ? DONE : DRAIN)
             : state;
  end
  always_comb begin
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
    a_step = busy;
    b_step = busy;
    src_tready = state == RUN && !a_pend && !b_pend && in_cnt < num_pix_r;
    a_in_tvalid = busy && a_pend;
    b_in_tvalid = busy && b_pend;
    a_out_tready = busy && !a_full;
    b_out_tready = busy && !b_full;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      num_pix_r <= '0;
      exp_out_r <= '0;
      in_cnt <= '0;
      out_cnt <= '0;
      mismatch <= 1'b0;
      mismatch_idx <= '0;
      timeout <= 1'b0;
      idle_cnt <= '0;
      a_pend <= 1'b0;
      b_pend <= 1'b0;
      a_hold <= '0;
      b_hold <= '0;
      a_wr <= '0;
      a_rd <= '0;
      b_wr <= '0;
      b_rd <= '0;
    end else if (go) begin
      num_pix_r <= num_pix;
      exp_out_r <= exp_out;
      in_cnt <= '0;
      out_cnt <= '0;
      mismatch <= 1'b0;
      mismatch_idx <= '0;
      timeout <= 1'b0;
      idle_cnt <= '0;
      a_pend <= 1'b0;
      b_pend <= 1'b0;
      a_wr <= '0;
      a_rd <= '0;
      b_wr <= '0;
      b_rd <= '0;
    end else begin
      a_pend <= busy && (src_hs || (a_pend && !a_in_hs));
      b_pend <= busy && (src_hs || (b_pend && !b_in_hs));
      if (src_hs) begin
        a_hold <= src_tdata;
        b_hold <= src_tdata;
        in_cnt <= in_cnt + 19'd1;
      end
      if (a_out_hs) a_wr <= a_wr + 1'b1;
      if (b_out_hs) b_wr <= b_wr + 1'b1;
      if (pop) begin
        a_rd <= a_rd + 1'b1;
        b_rd <= b_rd + 1'b1;
        out_cnt <= out_cnt + {18'd0, ~&out_cnt};
        if (a_mem[a_rd[AW-1:0]] != b_mem[b_rd[AW-1:0]] && !mismatch) begin
          mismatch <= 1'b1;
          mismatch_idx <= out_cnt;
        end
      end
      if (busy) idle_cnt <= any_hs ? '0 : idle_cnt + 1'b1;
      if (tmo_hit) timeout <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (a_out_hs) a_mem[a_wr[AW-1:0]] <= a_out_tdata;
    if (b_out_hs) b_mem[b_wr[AW-1:0]] <= b_out_tdata;
  end
endmodule
